// File: rtl/ctrl_pkg.sv
// Shared types and encodings for the fetch/decode/execute sequencer.
package ctrl_pkg;

    localparam int unsigned OPC_W = 4;
    localparam int unsigned BUS_W = 3;
    localparam int unsigned ALU_W = 2;
    localparam int unsigned CNT_W = 8;

    typedef logic [OPC_W-1:0] opc_t;

    localparam opc_t OP_NOP   = 4'h0;
    localparam opc_t OP_LOAD  = 4'h1;
    localparam opc_t OP_STORE = 4'h2;
    localparam opc_t OP_ADD   = 4'h3;
    localparam opc_t OP_SUB   = 4'h4;
    localparam opc_t OP_JMP   = 4'h5;
    localparam opc_t OP_JZ    = 4'h6;
    localparam opc_t OP_HALT  = 4'hF;

    localparam logic [BUS_W-1:0] BUS_NONE = 3'd0;
    localparam logic [BUS_W-1:0] BUS_PC   = 3'd1;
    localparam logic [BUS_W-1:0] BUS_MEM  = 3'd2;
    localparam logic [BUS_W-1:0] BUS_IR   = 3'd3;
    localparam logic [BUS_W-1:0] BUS_AC   = 3'd4;

    localparam logic [ALU_W-1:0] ALU_PASS = 2'd0;
    localparam logic [ALU_W-1:0] ALU_ADD  = 2'd1;
    localparam logic [ALU_W-1:0] ALU_SUB  = 2'd2;

    typedef enum logic [3:0] {
        S_IDLE, S_F_AR, S_F_MEM, S_F_IR, S_DEC,
        S_X_AR, S_X_MEM, S_X_WB, S_X_JMP, S_HALTED
    } state_e;

    typedef struct packed {
        logic [BUS_W-1:0] bus_sel;
        logic             ar_we;
        logic             pc_we;
        logic             pc_inc;
        logic             ir_we;
        logic             ac_we;
        logic [ALU_W-1:0] alu_op;
        logic             mem_rd;
        logic             mem_wr;
        logic             busy;
        logic             halted;
    } ctrl_t;

    // Moore control word for a state and the opcode it is working on.
    function automatic ctrl_t ctrl_decode(input state_e s, input opc_t opc);
        ctrl_t c;
        c = '0;
        case (s)
            S_F_AR:  begin c.bus_sel = BUS_PC; c.ar_we = 1'b1; end
            S_F_MEM: c.mem_rd = 1'b1;
            S_F_IR:  begin c.bus_sel = BUS_MEM; c.ir_we = 1'b1; c.pc_inc = 1'b1; end
            S_X_AR:  begin c.bus_sel = BUS_IR; c.ar_we = 1'b1; end
            S_X_MEM: begin
                if (opc == OP_STORE) begin
                    c.mem_wr  = 1'b1;
                    c.bus_sel = BUS_AC;
                end else begin
                    c.mem_rd = 1'b1;
                end
            end
            S_X_WB: begin
                c.bus_sel = BUS_MEM;
                c.ac_we   = 1'b1;
                c.alu_op  = (opc == OP_ADD) ? ALU_ADD :
                            (opc == OP_SUB) ? ALU_SUB : ALU_PASS;
            end
            S_X_JMP: begin c.bus_sel = BUS_IR; c.pc_we = 1'b1; end
            default: c = '0;
        endcase
        c.busy   = (s != S_IDLE) && (s != S_HALTED);
        c.halted = (s == S_HALTED);
        return c;
    endfunction

endpackage

// File: rtl/fetch_exec_ctrl_wait_timer.sv
// Memory wait counter; flags expiry when the last allowed wait cycle passes without ready.
module wait_timer
    import ctrl_pkg::*;
#(
    parameter int unsigned TIMEOUT = 15
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    input  logic ready,
    output logic expired
);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en && !ready) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    assign expired = en && !ready && (cnt_q == CNT_W'(TIMEOUT - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/fetch_exec_ctrl.sv
// Fetch/decode/execute sequencer for the 12-bit accumulator processor.
// Control outputs are registered from the decode of the next state and opcode.
module fetch_exec_ctrl
    import ctrl_pkg::*;
#(
    parameter int unsigned IR_width  = 12,
    parameter int unsigned OPC_width = 4,
    parameter int unsigned TIMEOUT   = 15
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [IR_width-1:0]  ir_data,
    input  logic                 mem_ready,
    input  logic                 z_flag,
    output logic [BUS_W-1:0]     bus_sel,
    output logic                 ar_we,
    output logic                 pc_we,
    output logic                 pc_inc,
    output logic                 ir_we,
    output logic                 ac_we,
    output logic [ALU_W-1:0]     alu_op,
    output logic                 mem_rd,
    output logic                 mem_wr,
    output logic                 busy,
    output logic                 halted,
    output logic                 err_illegal,
    output logic                 err_timeout
);

    state_e state_q, state_d;
    opc_t   opc_q, opc_d;
    ctrl_t  ctrl_q, ctrl_d;
    logic   err_ill_q, err_ill_d;
    logic   err_to_q, err_to_d;
    opc_t   ir_opc;
    logic   operand_unused;
    logic   in_mem;
    logic   expired;

    assign ir_opc         = OPC_W'(ir_data[IR_width-1 -: OPC_width]);
    assign operand_unused = ^ir_data[IR_width-OPC_width-1:0];
    assign in_mem         = (state_q == S_F_MEM) || (state_q == S_X_MEM);

    // Counter is held clear outside the memory states, so it starts at zero on entry.
    wait_timer #(.TIMEOUT(TIMEOUT)) u_wait_timer (
        .clk     (clk),
        .rst_n   (reset),
        .clr     (!in_mem),
        .en      (in_mem),
        .ready   (mem_ready),
        .expired (expired)
    );

    always_comb begin
        state_d   = state_q;
        opc_d     = opc_q;
        err_ill_d = err_ill_q;
        err_to_d  = err_to_q;
        case (state_q)
            S_IDLE:  if (start) state_d = S_F_AR;
            S_F_AR:  state_d = S_F_MEM;
            S_F_MEM: begin
                if (mem_ready) begin
                    state_d = S_F_IR;
                end else if (expired) begin
                    state_d  = S_HALTED;
                    err_to_d = 1'b1;
                end
            end
            S_F_IR:  state_d = S_DEC;
            S_DEC: begin
                opc_d = ir_opc;
                case (ir_opc)
                    OP_NOP:                              state_d = S_F_AR;
                    OP_LOAD, OP_ADD, OP_SUB, OP_STORE:   state_d = S_X_AR;
                    OP_JMP:                              state_d = S_X_JMP;
                    OP_JZ:   state_d = z_flag ? S_X_JMP : S_F_AR;
                    OP_HALT:                             state_d = S_HALTED;
                    default: begin
                        state_d   = S_F_AR;
                        err_ill_d = 1'b1;
                    end
                endcase
            end
            S_X_AR:  state_d = S_X_MEM;
            S_X_MEM: begin
                if (mem_ready) begin
                    state_d = (opc_q == OP_STORE) ? S_F_AR : S_X_WB;
                end else if (expired) begin
                    state_d  = S_HALTED;
                    err_to_d = 1'b1;
                end
            end
            S_X_WB, S_X_JMP: state_d = S_F_AR;
            S_HALTED: state_d = S_HALTED;
            default:  state_d = S_IDLE;
        endcase
        ctrl_d = ctrl_decode(state_d, opc_d);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= S_IDLE;
            opc_q     <= '0;
            ctrl_q    <= '0;
            err_ill_q <= 1'b0;
            err_to_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            opc_q     <= opc_d;
            ctrl_q    <= ctrl_d;
            err_ill_q <= err_ill_d;
            err_to_q  <= err_to_d;
        end
    end

    assign bus_sel     = ctrl_q.bus_sel;
    assign ar_we       = ctrl_q.ar_we;
    assign pc_we       = ctrl_q.pc_we;
    assign pc_inc      = ctrl_q.pc_inc;
    assign ir_we       = ctrl_q.ir_we;
    assign ac_we       = ctrl_q.ac_we;
    assign alu_op      = ctrl_q.alu_op;
    assign mem_rd      = ctrl_q.mem_rd;
    assign mem_wr      = ctrl_q.mem_wr;
    assign busy        = ctrl_q.busy;
    assign halted      = ctrl_q.halted;
    assign err_illegal = err_ill_q;
    assign err_timeout = err_to_q;

endmodule
